// File: rtl/writeback_arbiter_if.sv
// Writeback bus: the integer pipe and the FP unit on one side, the register file write port on the other.
interface writeback_arbiter_if;
    logic        int_valid;
    logic [5:0]  int_reg;
    logic [31:0] int_data;
    logic        fp_valid;
    logic        fp_ready;
    logic [5:0]  fp_reg;
    logic [31:0] fp_data;
    logic        regWrite;
    logic        float;
    logic [5:0]  writeReg;
    logic [31:0] writeData;
    logic [3:0]  fifo_count;
    logic        idle;

    modport master (
        output int_valid, int_reg, int_data, fp_valid, fp_reg, fp_data,
        input  fp_ready, regWrite, float, writeReg, writeData, fifo_count, idle
    );

    modport slave (
        input  int_valid, int_reg, int_data, fp_valid, fp_reg, fp_data,
        output fp_ready, regWrite, float, writeReg, writeData, fifo_count, idle
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Single register-file write port shared by an unstallable integer pipe and a queued FP unit.
// Define WB_FP_BYPASS_EN to let an FP result skip the empty queue when the write slot is free.
module writeback_arbiter #(
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst_n,
    writeback_arbiter_if.slave wb
);
    localparam int PW = $clog2(DEPTH);

    logic [5:0]    qReg  [DEPTH];
    logic [31:0]   qData [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [3:0]    count;
    logic [3:0]    countNext;

    logic        regWriteR;
    logic        floatR;
    logic [5:0]  writeRegR;
    logic [31:0] writeDataR;
    logic        idleR;

    logic intWrite;
    logic push;
    logic pushQ;
    logic pop;
    logic bypass;
    logic regWriteNext;

    // fp_ready looks only at the registered count, so a same-cycle pop never frees a slot early
    assign wb.fp_ready   = rst_n && (count < 4'(DEPTH));
    assign wb.fifo_count = count;
    assign wb.regWrite   = regWriteR;
    assign wb.float      = floatR;
    assign wb.writeReg   = writeRegR;
    assign wb.writeData  = writeDataR;
    assign wb.idle       = idleR;

    always_comb begin
        intWrite = wb.int_valid && (wb.int_reg != 6'd0);
        push     = wb.fp_valid && wb.fp_ready;
        pop      = !intWrite && (count != 4'd0);
`ifdef WB_FP_BYPASS_EN
        bypass   = !intWrite && (count == 4'd0) && push;
`else
        bypass   = 1'b0;
`endif
        pushQ        = push && !bypass;
        countNext    = count + {3'b000, pushQ} - {3'b000, pop};
        regWriteNext = intWrite || pop || bypass;
    end

    always_ff @(posedge clk) begin
        if (pushQ) begin
            qReg[wrPtr]  <= wb.fp_reg;
            qData[wrPtr] <= wb.fp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 4'd0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            regWriteR  <= 1'b0;
            floatR     <= 1'b0;
            writeRegR  <= 6'd0;
            writeDataR <= 32'd0;
            idleR      <= 1'b1;
        end else begin
            count     <= countNext;
            idleR     <= (countNext == 4'd0) && !regWriteNext;
            regWriteR <= regWriteNext;
            if (pushQ) wrPtr <= wrPtr + PW'(1);
            if (pop)   rdPtr <= rdPtr + PW'(1);
            // write-port fields hold their last value on cycles with no write
            if (intWrite) begin
                floatR     <= 1'b0;
                writeRegR  <= wb.int_reg;
                writeDataR <= wb.int_data;
            end else if (pop) begin
                floatR     <= 1'b1;
                writeRegR  <= qReg[rdPtr];
                writeDataR <= qData[rdPtr];
            end else if (bypass) begin
                floatR     <= 1'b1;
                writeRegR  <= wb.fp_reg;
                writeDataR <= wb.fp_data;
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter; expected writes go to a scoreboard checked by a negedge monitor.
module tb_writeback_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    writeback_arbiter_if bus();
    writeback_arbiter #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .wb(bus));

    typedef struct {
        logic        flt;
        logic [5:0]  rg;
        logic [31:0] dt;
        int          cy;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int passCnt = 0;
    int totalCnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        totalCnt++;
        if (act === req) passCnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic iv, input logic [5:0] ir, input logic [31:0] id,
                         input logic fv, input logic [5:0] fr, input logic [31:0] fd);
        bus.int_valid = iv;
        bus.int_reg   = ir;
        bus.int_data  = id;
        bus.fp_valid  = fv;
        bus.fp_reg    = fr;
        bus.fp_data   = fd;
    endtask

    task automatic expWr(input logic flt, input logic [5:0] rg, input logic [31:0] dt, input int cy);
        exp_t e;
        e.flt = flt;
        e.rg  = rg;
        e.dt  = dt;
        e.cy  = cy;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.regWrite === 1'b1) begin
            if (sb.size() == 0) begin
                totalCnt++;
                $display("FAIL spurious_write: got reg %0d data 0x%0h float %0b at cycle %0d, expected no write",
                         bus.writeReg, bus.writeData, bus.float, cyc);
            end else begin
                e = sb.pop_front();
                chk("wr_float", 32'(bus.float), 32'(e.flt));
                chk("wr_reg", 32'(bus.writeReg), 32'(e.rg));
                chk("wr_data", bus.writeData, e.dt);
                chk("wr_cycle", 32'(cyc), 32'(e.cy));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        int j;
        setIn(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_regWrite", 32'(bus.regWrite), 32'd0);
        chk("rst_float", 32'(bus.float), 32'd0);
        chk("rst_writeReg", 32'(bus.writeReg), 32'd0);
        chk("rst_writeData", bus.writeData, 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_idle", 32'(bus.idle), 32'd1);
        chk("rst_fp_ready", 32'(bus.fp_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_fp_ready", 32'(bus.fp_ready), 32'd1);
        chk("rel_idle", 32'(bus.idle), 32'd1);

        // single integer write
        setIn(1'b1, 6'd5, 32'h12345678, 1'b0, 6'd0, 32'd0);
        expWr(1'b0, 6'd5, 32'h12345678, cyc + 1);
        tick();
        chk("int_idle_busy", 32'(bus.idle), 32'd0);
        setIn(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        tick();
        chk("int_idle_back", 32'(bus.idle), 32'd1);

        // int_reg 0 frees the slot for a queued FP entry
        setIn(1'b1, 6'd7, 32'hA5A50007, 1'b1, 6'd3, 32'h3F800000);
        expWr(1'b0, 6'd7, 32'hA5A50007, cyc + 1);
        tick();
        chk("r0_count_one", 32'(bus.fifo_count), 32'd1);
        setIn(1'b1, 6'd0, 32'hDEADBEEF, 1'b0, 6'd0, 32'd0);
        expWr(1'b1, 6'd3, 32'h3F800000, cyc + 1);
        tick();
        chk("r0_count_zero", 32'(bus.fifo_count), 32'd0);
        setIn(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        tick();

        // integer starvation fills the queue, then drains in order
        j = 0;
        for (int k = 0; k < 6; k++) begin
            setIn(1'b1, 6'(10 + k), 32'h1000 + 32'(k), 1'b1, 6'(20 + j), 32'h2000 + 32'(j));
            chk("fill_fp_ready", 32'(bus.fp_ready), (k < 4) ? 32'd1 : 32'd0);
            expWr(1'b0, 6'(10 + k), 32'h1000 + 32'(k), cyc + 1);
            if (k < 4) j++;
            tick();
            chk("fill_count", 32'(bus.fifo_count), (k < 4) ? 32'(k + 1) : 32'd4);
        end
        chk("full_fp_ready", 32'(bus.fp_ready), 32'd0);
        setIn(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        for (int m = 0; m < 4; m++) expWr(1'b1, 6'(20 + m), 32'h2000 + 32'(m), cyc + 1 + m);
        for (int m = 0; m < 4; m++) tick();
        chk("drain_count", 32'(bus.fifo_count), 32'd0);
        tick();
        chk("hold_regWrite", 32'(bus.regWrite), 32'd0);
        chk("hold_writeReg", 32'(bus.writeReg), 32'd23);
        chk("hold_writeData", bus.writeData, 32'h2003);
        chk("hold_float", 32'(bus.float), 32'd1);
        chk("hold_idle", 32'(bus.idle), 32'd1);

        // push and pop on the same edge
        setIn(1'b1, 6'd11, 32'h0000000B, 1'b1, 6'd30, 32'h3000);
        expWr(1'b0, 6'd11, 32'h0000000B, cyc + 1);
        tick();
        setIn(1'b0, 6'd0, 32'd0, 1'b1, 6'd31, 32'h3100);
        expWr(1'b1, 6'd30, 32'h3000, cyc + 1);
        tick();
        chk("pushpop_count", 32'(bus.fifo_count), 32'd1);
        setIn(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        expWr(1'b1, 6'd31, 32'h3100, cyc + 1);
        tick();
        chk("pushpop_empty", 32'(bus.fifo_count), 32'd0);
        tick();

        // reset mid-cycle with two queued entries and a write on the port
        setIn(1'b1, 6'd12, 32'h0000000C, 1'b1, 6'd40, 32'h4000);
        expWr(1'b0, 6'd12, 32'h0000000C, cyc + 1);
        tick();
        setIn(1'b1, 6'd13, 32'h0000000D, 1'b1, 6'd41, 32'h4100);
        tick();
        chk("pre_rst_count", 32'(bus.fifo_count), 32'd2);
        #3;
        rst_n = 1'b0;
        setIn(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        #1;
        chk("mid_rst_regWrite", 32'(bus.regWrite), 32'd0);
        chk("mid_rst_float", 32'(bus.float), 32'd0);
        chk("mid_rst_writeReg", 32'(bus.writeReg), 32'd0);
        chk("mid_rst_writeData", bus.writeData, 32'd0);
        chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
        chk("mid_rst_idle", 32'(bus.idle), 32'd1);
        chk("mid_rst_fp_ready", 32'(bus.fp_ready), 32'd0);
        #2 rst_n = 1'b1;
        for (int m = 0; m < 4; m++) tick();
        chk("post_rst_count", 32'(bus.fifo_count), 32'd0);
        chk("post_rst_idle", 32'(bus.idle), 32'd1);
        chk("post_rst_fp_ready", 32'(bus.fp_ready), 32'd1);

        // FP write to register 0 into an empty queue
        setIn(1'b0, 6'd0, 32'd0, 1'b1, 6'd0, 32'h40000000);
        chk("fp0_ready", 32'(bus.fp_ready), 32'd1);
`ifdef WB_FP_BYPASS_EN
        expWr(1'b1, 6'd0, 32'h40000000, cyc + 1);
        tick();
        chk("fp0_count", 32'(bus.fifo_count), 32'd0);
`else
        expWr(1'b1, 6'd0, 32'h40000000, cyc + 2);
        tick();
        chk("fp0_count", 32'(bus.fifo_count), 32'd1);
`endif
        setIn(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        tick();
        tick();
        chk("fp0_drained", 32'(bus.fifo_count), 32'd0);
        tick();
        tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
